trng_req_arbiter: RTL and testbench

Shares the single TRNG entropy output among NUM_REQ requesters, such as the CPU bus slave, the key-load engine and DMA. It grants one requester at a time in round-robin order and waits for the TRNG control unit's ready. It then delivers the 32-bit word only to the granted requester, issues the read-acknowledge that makes the TRNG flush and regenerate, and scrubs its own copy. It also propagates an unrecoverable TRNG failure to all requesters.

---
 rtl/trng_pkg.sv | 9 +
 rtl/trng_rr_pick.sv | 29 ++
 rtl/trng_req_arbiter.sv | 114 +++++++++++
 tb/tb_trng_req_arbiter.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/trng_pkg.sv
// trng_pkg: shared types and constants for the TRNG request arbiter.
package trng_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_RND, ACK, FAULT} arb_state_e;
  localparam int TRNG_DATA_W = 32;
  localparam int DEF_TIMEOUT_CYC = 255;
  function automatic int wrap_idx(input int v, input int n);
    return (v >= n) ? v - n : v;
  endfunction
endpackage

// File: rtl/trng_rr_pick.sv
// trng_rr_pick: combinational round-robin picker, first set request at or after ptr_i.
module trng_rr_pick
  import trng_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [IW-1:0] k;
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int i = 0; i < N; i++) begin
      k = IW'(wrap_idx(int'(ptr_i) + i, N));
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        idx_o    = k;
        gnt_o[k] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/trng_req_arbiter.sv
// trng_req_arbiter: round-robin sharing of one TRNG word stream among NUM_REQ requesters,
// with read-acknowledge, timeout, sticky fault propagation and scrubbing of the captured word.
module trng_req_arbiter
  import trng_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = TRNG_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [NUM_REQ-1:0] rnd_valid_o,
  output logic [NUM_REQ-1:0] err_o,
  output logic [DATA_W-1:0]  rnd_data_o,
  output logic               fault_o,
  input  logic               trng_rnd_ready_i,
  input  logic [DATA_W-1:0]  trng_rnd_data_i,
  output logic               trng_ack_read_o,
  input  logic               trng_fault_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]      idx_q, idx_d, ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx, nxt_ptr;
  logic               pick_any, held, timeout;

  trng_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign nxt_ptr = IW'(wrap_idx(int'(idx_q) + 1, NUM_REQ));
  assign held    = |(req_i & gnt_q);
  assign timeout = cnt_q == CW'(TIMEOUT_CYC);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // data_d defaults to zero so the captured word lives exactly one cycle (ACK)
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    data_d  = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (trng_fault_i) state_d = FAULT;
        else if (pick_any) begin
          gnt_d   = pick_gnt;
          idx_d   = pick_idx;
          state_d = WAIT_RND;
        end
      end
      WAIT_RND: begin
        if (trng_fault_i) begin
          gnt_d   = '0;
          state_d = FAULT;
        end else if (!held || (!trng_rnd_ready_i && timeout)) begin
          gnt_d   = '0;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end else if (trng_rnd_ready_i) begin
          data_d  = trng_rnd_data_i;
          state_d = ACK;
        end else cnt_d = cnt_q + 1'b1;
      end
      ACK: begin
        gnt_d   = '0;
        ptr_d   = nxt_ptr;
        state_d = trng_fault_i ? FAULT : IDLE;
      end
      default: gnt_d = '0;
    endcase
  end

  // err_o is asserted in the deciding WAIT_RND cycle so requesters can drop req_i before IDLE samples it
  always_comb begin
    gnt_o           = gnt_q;
    rnd_valid_o     = (state_q == ACK) ? gnt_q : '0;
    err_o           = (state_q == WAIT_RND && (trng_fault_i || (held && !trng_rnd_ready_i && timeout))) ? gnt_q : '0;
    rnd_data_o      = data_q;
    fault_o         = state_q == FAULT;
    trng_ack_read_o = state_q == ACK;
  end
endmodule

// File: tb/tb_trng_req_arbiter.sv
// tb_trng_req_arbiter: directed stimulus with a queue-based scoreboard for deliveries and errors.
module tb_trng_req_arbiter;
  typedef struct {
    logic        is_err;
    logic [3:0]  vec;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt, rnd_valid, err;
  logic [31:0] rnd_data;
  logic        fault, ack;
  logic        ready = 1'b0;
  logic [31:0] tdata = '0;
  logic        tfault = 1'b0;

  exp_t q[$];
  int total = 0;
  int bad = 0;
  int acks = 0;
  int n;

  trng_req_arbiter #(.NUM_REQ(4), .DATA_W(32), .TIMEOUT_CYC(255)) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_i            (req),
    .gnt_o            (gnt),
    .rnd_valid_o      (rnd_valid),
    .err_o            (err),
    .rnd_data_o       (rnd_data),
    .fault_o          (fault),
    .trng_rnd_ready_i (ready),
    .trng_rnd_data_i  (tdata),
    .trng_ack_read_o  (ack),
    .trng_fault_i     (tfault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic is_err, input logic [3:0] vec, input logic [31:0] data);
    exp_t e;
    e.is_err = is_err;
    e.vec    = vec;
    e.data   = data;
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    req    = '0;
    ready  = 1'b0;
    tfault = 1'b0;
    tdata  = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) acks++;
      if (|rnd_valid || |err) begin
        if (q.size() == 0) check("unexpected_event", {28'b0, rnd_valid, err, rnd_data}, 64'h0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("sb_kind", {63'b0, |err}, {63'b0, e.is_err});
          check("sb_vec", {60'b0, e.is_err ? err : rnd_valid}, {60'b0, e.vec});
          check("sb_data", {32'b0, rnd_data}, {32'b0, e.data});
        end
        check("ack_matches_valid", {63'b0, ack}, {63'b0, |rnd_valid});
      end else if (ack || rnd_data != 0) check("idle_hygiene", {31'b0, ack, rnd_data}, 64'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    #1;
    check("reset_outputs", {gnt, rnd_valid, err, rnd_data, fault, ack}, 64'h0);
    do_reset();

    // single delivery, ready already high
    req = 4'b0001; ready = 1'b1; tdata = 32'hDEADBEEF;
    push(1'b0, 4'b0001, 32'hDEADBEEF);
    tick();
    check("t1_gnt_c1", {60'b0, gnt}, 64'h1);
    tick();
    check("t1_valid_c2", {28'b0, rnd_valid, rnd_data}, {28'b0, 4'b0001, 32'hDEADBEEF});
    check("t1_ack_c2", {63'b0, ack}, 64'h1);
    req = '0;
    tick();
    check("t1_scrub_c3", {28'b0, gnt, rnd_data}, 64'h0);

    // round robin with all requesting
    do_reset();
    req = 4'b1111; ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tdata = 32'hA000_0000 + k;
      push(1'b0, 4'b0001 << (k % 4), 32'hA000_0000 + k);
      tick();
      check("t2_rr_gnt", {60'b0, gnt}, {60'b0, 4'b0001 << (k % 4)});
      tick();
      tick();
    end
    req = '0;
    tick();
    check("t2_acks", 64'(acks), 64'd6);

    // timeout with ready low
    do_reset();
    req = 4'b0100;
    push(1'b1, 4'b0100, 32'h0);
    tick();
    check("t3_gnt", {60'b0, gnt}, 64'h4);
    n = 1;
    while (err == 0 && n < 400) begin
      tick();
      n++;
    end
    check("t3_wait_cycles", 64'(n), 64'd256);
    tick();
    req = '0;
    check("t3_gnt_cleared", {60'b0, gnt}, 64'h0);
    tick();
    check("t3_no_regrant", {60'b0, gnt}, 64'h0);
    check("t3_acks", 64'(acks), 64'd6);

    // abort in WAIT_RND, then pointer must have advanced to 2
    do_reset();
    req = 4'b0010;
    tick();
    check("t4_gnt", {60'b0, gnt}, 64'h2);
    repeat (3) tick();
    req = '0;
    tick();
    check("t4_abort_clear", {60'b0, gnt}, 64'h0);
    req = 4'b0110; ready = 1'b1; tdata = 32'h1234_5678;
    push(1'b0, 4'b0100, 32'h1234_5678);
    tick();
    check("t4_ptr_advanced", {60'b0, gnt}, 64'h4);
    tick();
    req = '0;
    tick();

    // fault while granted
    do_reset();
    req = 4'b0010;
    tick();
    check("t5_gnt", {60'b0, gnt}, 64'h2);
    push(1'b1, 4'b0010, 32'h0);
    tfault = 1'b1;
    #1;
    check("t5_err", {60'b0, err}, 64'h2);
    tick();
    tfault = 1'b0; req = 4'b1111; ready = 1'b1;
    check("t5_fault_entry", {59'b0, fault, err}, {59'b0, 1'b1, 4'b0});
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t5_locked", {27'b0, fault, gnt, ack, rnd_data}, {27'b0, 1'b1, 4'b0, 1'b0, 32'b0});
    end
    rst_n = 1'b0;
    #1;
    check("t5_reset_clears_fault", {63'b0, fault}, 64'h0);
    req = '0; ready = 1'b0;
    tick();
    rst_n = 1'b1;

    // asynchronous reset in ACK
    do_reset();
    req = 4'b0001; ready = 1'b1; tdata = 32'hCAFEF00D;
    tick();
    tick();
    check("t6_in_ack", {27'b0, rnd_valid, ack, rnd_data}, {27'b0, 4'b0001, 1'b1, 32'hCAFEF00D});
    #1 rst_n = 1'b0;
    #1;
    check("t6_async_reset", {gnt, rnd_valid, err, rnd_data, fault, ack}, 64'h0);
    tick();
    rst_n = 1'b1;
    push(1'b0, 4'b0001, 32'hCAFEF00D);
    tick();
    check("t6_resume_gnt", {60'b0, gnt}, 64'h1);
    tick();
    req = '0;
    repeat (3) tick();

    check("sb_drained", 64'(q.size()), 64'd0);
    check("total_acks", 64'(acks), 64'd8);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
